// File: rtl/disp_pkg.sv
// Shared types and constants for the 4-digit multiplexed display scanner.
// Anode patterns are active-low; digit 0 is the rightmost position.
package disp_pkg;

    localparam int DIG_W = 2;

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;

    function automatic logic [3:0] an_pattern(input logic [DIG_W-1:0] dig);
        logic [3:0] pat;
        case (dig)
            2'd0:    pat = AN_DIG0;
            2'd1:    pat = AN_DIG1;
            2'd2:    pat = AN_DIG2;
            2'd3:    pat = AN_DIG3;
            default: pat = AN_OFF;
        endcase
        return pat;
    endfunction

    // A digit is a leading zero when it and every more-significant nibble are zero.
    function automatic logic lz_blank(input logic [15:0] val, input logic [DIG_W-1:0] dig);
        logic blank;
        case (dig)
            2'd1:    blank = (val[15:4]  == 12'h000);
            2'd2:    blank = (val[15:8]  == 8'h00);
            2'd3:    blank = (val[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
        return blank;
    endfunction

endpackage

// File: rtl/disp_slot_timer.sv
// Slot counter 0..DIV-1 with digit index advancing on wrap; en_i low freezes both.
// Latency: wrap_o/guard_end_o are combinational decodes of the held count; no backpressure.
module disp_slot_timer
    import disp_pkg::*;
#(
    parameter int DIV  = 50000,
    parameter int DEAD = 500
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic             wrap_o,
    output logic             guard_end_o,
    output logic [DIG_W-1:0] digit_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GEND = CNT_W'(DEAD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIG_W-1:0] dig_q, dig_d;

    assign wrap_o      = en_i && (cnt_q == CNT_LAST);
    assign guard_end_o = en_i && (cnt_q == CNT_GEND);
    assign digit_o     = dig_q;

    always_comb begin
        cnt_d = cnt_q;
        dig_d = dig_q;
        if (wrap_o) begin
            cnt_d = '0;
            dig_d = dig_q + DIG_W'(1);
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            dig_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            dig_q <= dig_d;
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 4-digit BCD scanner with per-slot anode guard, leading-zero blanking and a
// one-deep update buffer committed only at frame end. an/bcd lag state by one cycle.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DIV  = 50000,
    parameter int DEAD = 500
) (
    input  logic        clk_e,
    input  logic        rst,
    input  logic        en,
    input  logic        lzs,
    input  logic        upd_valid,
    input  logic [15:0] upd_data,
    output logic        upd_ready,
    output logic [3:0]  an,
    output logic [3:0]  bcd,
    output logic        frame_done
);

    logic             wrap;
    logic             guard_end;
    logic [DIG_W-1:0] digit;
    logic             frame_end;
    logic             xfer;
    logic [3:0]       cur_nib;

    state_t      state_q;
    logic [3:0]  an_q;
    logic [3:0]  bcd_q;
    logic        pend_vld_q;
    logic [15:0] pend_q;
    logic [15:0] disp_q;

    disp_slot_timer #(
        .DIV  (DIV),
        .DEAD (DEAD)
    ) u_timer (
        .clk_i       (clk_e),
        .rst_i       (rst),
        .en_i        (en),
        .wrap_o      (wrap),
        .guard_end_o (guard_end),
        .digit_o     (digit)
    );

    assign frame_end = wrap && (digit == DIG_W'(3));
    assign xfer      = upd_valid && !pend_vld_q;
    assign cur_nib   = disp_q[{digit, 2'b00} +: 4];

    assign frame_done = frame_end && !rst;
    assign upd_ready  = !pend_vld_q;
    assign an         = an_q;
    assign bcd        = bcd_q;

    always_ff @(posedge clk_e) begin
        if (rst) begin
            state_q <= GUARD;
            an_q    <= AN_OFF;
            bcd_q   <= 4'h0;
        end else begin
            case (state_q)
                GUARD:   if (guard_end) state_q <= SHOW;
                SHOW:    if (wrap)      state_q <= GUARD;
                default:                state_q <= GUARD;
            endcase
            // bcd keeps its last value through the guard and while scanning is paused.
            if (en && state_q == SHOW) begin
                bcd_q <= cur_nib;
                an_q  <= (lzs && lz_blank(disp_q, digit)) ? AN_OFF : an_pattern(digit);
            end else begin
                an_q  <= AN_OFF;
            end
        end
    end

    // Pending is only drained at the digit-3 wrap so a frame never mixes two values.
    always_ff @(posedge clk_e) begin
        if (rst) begin
            pend_vld_q <= 1'b0;
            pend_q     <= 16'h0000;
            disp_q     <= 16'h0000;
        end else if (xfer) begin
            pend_q     <= upd_data;
            pend_vld_q <= 1'b1;
        end else if (frame_end && pend_vld_q) begin
            disp_q     <= pend_q;
            pend_vld_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl at DIV=8, DEAD=2: a table of whole frames plus
// hand sequences for pause/resume and mid-frame reset.
module tb_disp_scan_ctrl;

    logic        clk_e = 1'b0;
    logic        rst;
    logic        en;
    logic        lzs;
    logic        upd_valid;
    logic [15:0] upd_data;
    logic        upd_ready;
    logic [3:0]  an;
    logic [3:0]  bcd;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    logic m_pend = 1'b0;

    disp_scan_ctrl #(
        .DIV  (8),
        .DEAD (2)
    ) dut (
        .clk_e      (clk_e),
        .rst        (rst),
        .en         (en),
        .lzs        (lzs),
        .upd_valid  (upd_valid),
        .upd_data   (upd_data),
        .upd_ready  (upd_ready),
        .an         (an),
        .bcd        (bcd),
        .frame_done (frame_done)
    );

    always #5 clk_e = ~clk_e;

    // One frame: lzs setting, at most two offers (slot position or -1), and the
    // hand-computed value shown plus which digits must stay dark.
    typedef struct {
        logic            lzs;
        int              offer_at;
        logic [15:0]     offer_dat;
        int              ign_at;
        logic [15:0]     ign_dat;
        logic [3:0][3:0] nib;
        logic [3:0]      blank;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(input logic l, input int oa, input logic [15:0] od,
                                input int ia, input logic [15:0] id,
                                input logic [15:0] shown, input logic [3:0] blk);
        vec_t v;
        v.lzs       = l;
        v.offer_at  = oa;
        v.offer_dat = od;
        v.ign_at    = ia;
        v.ign_dat   = id;
        v.nib       = shown;
        v.blank     = blk;
        return v;
    endfunction

    task automatic step();
        @(posedge clk_e);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input int fidx);
        logic [3:0] exp_an;
        logic       pend_before;
        int         p, d, c;
        lzs = v.lzs;
        for (int j = 1; j <= 32; j++) begin
            p = j - 1;
            if (p == v.offer_at) begin
                upd_valid = 1'b1;
                upd_data  = v.offer_dat;
            end else if (p == v.ign_at) begin
                upd_valid = 1'b1;
                upd_data  = v.ign_dat;
            end else begin
                upd_valid = 1'b0;
            end
            step();
            pend_before = m_pend;
            if (j == 32 && pend_before) m_pend = 1'b0;
            if (upd_valid && !pend_before) m_pend = 1'b1;
            d = p / 8;
            c = p % 8;
            exp_an = 4'hF;
            if (c >= 2 && !v.blank[d]) exp_an[d] = 1'b0;
            chk($sformatf("an f%0d p%0d", fidx, p), an, exp_an);
            if (exp_an != 4'hF) chk($sformatf("bcd f%0d p%0d", fidx, p), bcd, v.nib[d]);
            chk($sformatf("frame_done f%0d p%0d", fidx, p), frame_done, j == 31);
            chk($sformatf("upd_ready f%0d p%0d", fidx, p), upd_ready, !m_pend);
        end
        upd_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = mk(1'b0,  0, 16'h1234, -1, 16'h0000, 16'h0000, 4'b0000);
        vecs[1] = mk(1'b0,  0, 16'h0007, -1, 16'h0000, 16'h1234, 4'b0000);
        vecs[2] = mk(1'b1, -1, 16'h0000, -1, 16'h0000, 16'h0007, 4'b1110);
        vecs[3] = mk(1'b0,  0, 16'hAAAA, -1, 16'h0000, 16'h0007, 4'b0000);
        vecs[4] = mk(1'b0, 13, 16'h5555, 20, 16'h9999, 16'hAAAA, 4'b0000);
        vecs[5] = mk(1'b0, -1, 16'h0000, -1, 16'h0000, 16'h5555, 4'b0000);
        vecs[6] = mk(1'b1,  0, 16'h0300, -1, 16'h0000, 16'h5555, 4'b0000);
        vecs[7] = mk(1'b1,  0, 16'h00F0, -1, 16'h0000, 16'h0300, 4'b1000);
        vecs[8] = mk(1'b1,  0, 16'h0000, -1, 16'h0000, 16'h00F0, 4'b1100);
        vecs[9] = mk(1'b1,  0, 16'h4321, -1, 16'h0000, 16'h0000, 4'b1110);

        rst       = 1'b1;
        en        = 1'b0;
        lzs       = 1'b0;
        upd_valid = 1'b0;
        upd_data  = 16'h0000;
        step();
        step();
        chk("reset an", an, 4'hF);
        chk("reset bcd", bcd, 4'h0);
        chk("reset upd_ready", upd_ready, 1'b1);
        chk("reset frame_done", frame_done, 1'b0);

        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 10; i++) run_frame(vecs[i], i);

        // Pause during digit 2 SHOW with 4321 displayed, offering 8888 while paused.
        lzs = 1'b0;
        repeat (20) step();
        chk("pre-pause an", an, 4'b1011);
        chk("pre-pause bcd", bcd, 4'h3);
        en = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            upd_valid = (k == 5);
            upd_data  = 16'h8888;
            step();
            chk($sformatf("paused an k%0d", k), an, 4'hF);
            chk($sformatf("paused frame_done k%0d", k), frame_done, 1'b0);
        end
        upd_valid = 1'b0;
        chk("paused upd_ready", upd_ready, 1'b0);
        en = 1'b1;
        for (int m = 1; m <= 12; m++) begin
            step();
            if (m == 1) begin
                chk("resume an m1", an, 4'b1011);
                chk("resume bcd m1", bcd, 4'h3);
            end
            if (m == 4)  chk("resume an m4", an, 4'b1011);
            if (m == 5)  chk("resume an m5", an, 4'hF);
            if (m == 7) begin
                chk("resume an m7", an, 4'b0111);
                chk("resume bcd m7", bcd, 4'h4);
            end
            if (m == 10) chk("resume frame_done m10", frame_done, 1'b0);
            if (m == 11) begin
                chk("resume frame_done m11", frame_done, 1'b1);
                chk("resume upd_ready m11", upd_ready, 1'b0);
            end
            if (m == 12) chk("resume upd_ready m12", upd_ready, 1'b1);
        end
        m_pend = 1'b0;
        run_frame(mk(1'b0, -1, 16'h0000, -1, 16'h0000, 16'h8888, 4'b0000), 10);

        // Reset mid-frame while an update is offered.
        repeat (10) step();
        rst       = 1'b1;
        upd_valid = 1'b1;
        upd_data  = 16'h9999;
        step();
        chk("midreset an", an, 4'hF);
        chk("midreset bcd", bcd, 4'h0);
        chk("midreset upd_ready", upd_ready, 1'b1);
        chk("midreset frame_done", frame_done, 1'b0);
        rst       = 1'b0;
        upd_valid = 1'b0;
        m_pend    = 1'b0;
        run_frame(mk(1'b0, -1, 16'h0000, -1, 16'h0000, 16'h0000, 4'b0000), 11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
